filter_switch_controller: RTL and testbench

//  Sequences filter changes on the filter bank (bypass/lowpass/highpass/bandpass).

---
 rtl/filter_switch_controller.sv | 151 +++++++++++++++
 tb/tb_filter_switch_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_switch_controller.sv
// Click-free filter switching: debounces the filter request, fades audio out,
// swaps the filter select while flushing filter state, then fades back in.
module filter_switch_controller #(
  parameter int unsigned RAMP_LOG2     = 6,
  parameter int unsigned FLUSH_SAMPLES = 4,
  parameter int unsigned DEBOUNCE      = 16
) (
  input  logic        AUD_BCLK,
  input  logic        reset_n,
  input  logic        AUD_DACLRCK,
  input  logic [1:0]  filter_choice_req,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic [1:0]  filter_choice,
  output logic        filter_reset,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned GW = RAMP_LOG2 + 1;
  localparam int unsigned PW = DW + GW + 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam int unsigned FW = $clog2(FLUSH_SAMPLES + 1);

  localparam logic [GW-1:0] GAIN_FULL = GW'(1 << RAMP_LOG2);
  localparam logic [CW-1:0] DEB_CNT   = CW'(DEBOUNCE);
  localparam logic [FW-1:0] FLUSH_CNT = FW'(FLUSH_SAMPLES);

  typedef enum logic [1:0] {IDLE, FADE_OUT, FLUSH, FADE_IN} state_t;

  state_t        state, state_n;
  logic [GW-1:0] gain, gain_n;
  logic [CW-1:0] deb_cnt, deb_cnt_n;
  logic [FW-1:0] flush_cnt, flush_cnt_n;
  logic [1:0]    req_prev, req_prev_n;
  logic [1:0]    target, target_n;
  logic [1:0]    filter_choice_n;
  logic          filter_reset_n;
  logic          busy_n;
  logic [2:0]    lrck_sync;
  logic          tick_c;

  // Two-flop synchronizer plus one history flop for rising-edge detect
  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) lrck_sync <= '0;
    else          lrck_sync <= {lrck_sync[1:0], AUD_DACLRCK};
  end

  assign tick_c = lrck_sync[1] & ~lrck_sync[2];

  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gain          <= GAIN_FULL;
      deb_cnt       <= '0;
      flush_cnt     <= '0;
      req_prev      <= '0;
      target        <= '0;
      filter_choice <= '0;
      filter_reset  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      gain          <= gain_n;
      deb_cnt       <= deb_cnt_n;
      flush_cnt     <= flush_cnt_n;
      req_prev      <= req_prev_n;
      target        <= target_n;
      filter_choice <= filter_choice_n;
      filter_reset  <= filter_reset_n;
      busy          <= busy_n;
    end
  end

  always_comb begin
    state_n         = state;
    gain_n          = gain;
    deb_cnt_n       = deb_cnt;
    flush_cnt_n     = flush_cnt;
    req_prev_n      = req_prev;
    target_n        = target;
    filter_choice_n = filter_choice;
    filter_reset_n  = filter_reset;
    busy_n          = busy;
    if (tick_c) begin
      req_prev_n = filter_choice_req;
      unique case (state)
        IDLE: begin
          // A changed request restarts the count with this sample as the first
          if (filter_choice_req == filter_choice)  deb_cnt_n = '0;
          else if (filter_choice_req != req_prev)  deb_cnt_n = CW'(1);
          else                                     deb_cnt_n = deb_cnt + CW'(1);
          if (deb_cnt_n == DEB_CNT) begin
            target_n  = filter_choice_req;
            busy_n    = 1'b1;
            deb_cnt_n = '0;
            state_n   = FADE_OUT;
          end
        end
        FADE_OUT: begin
          gain_n = gain - GW'(1);
          if (gain == GW'(1)) begin
            filter_choice_n = target;
            filter_reset_n  = 1'b1;
            flush_cnt_n     = '0;
            state_n         = FLUSH;
          end
        end
        FLUSH: begin
          flush_cnt_n = flush_cnt + FW'(1);
          if (flush_cnt_n == FLUSH_CNT) begin
            filter_reset_n = 1'b0;
            state_n        = FADE_IN;
          end
        end
        FADE_IN: begin
          gain_n = gain + GW'(1);
          if (gain_n == GAIN_FULL) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Gain scaling: full-width signed product, arithmetic shift, truncate to 32 bits
  logic signed [PW-1:0] gain_s_c, in_l_s_c, in_r_s_c, prod_l_c, prod_r_c;

  always_comb begin
    gain_s_c = PW'({1'b0, gain});
    in_l_s_c = PW'(signed'(left_channel_audio_in));
    in_r_s_c = PW'(signed'(right_channel_audio_in));
    prod_l_c = in_l_s_c * gain_s_c;
    prod_r_c = in_r_s_c * gain_s_c;
  end

  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) begin
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      left_channel_audio_out  <= DW'(prod_l_c >>> RAMP_LOG2);
      right_channel_audio_out <= DW'(prod_r_c >>> RAMP_LOG2);
    end
  end

endmodule

// File: tb/tb_filter_switch_controller.sv
// Scoreboard bench for filter_switch_controller: stimulus queues expected
// outputs per sample, a monitor compares them once the sample has settled.
module tb_filter_switch_controller;

  logic        AUD_BCLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        AUD_DACLRCK = 1'b0;
  logic [1:0]  filter_choice_req = 2'b00;
  logic [31:0] left_channel_audio_in = 32'h0000_1000;
  logic [31:0] right_channel_audio_in = 32'hFFFF_FFE0;
  logic [1:0]  filter_choice;
  logic        filter_reset;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        busy;

  filter_switch_controller dut (
    .AUD_BCLK                (AUD_BCLK),
    .reset_n                 (reset_n),
    .AUD_DACLRCK             (AUD_DACLRCK),
    .filter_choice_req       (filter_choice_req),
    .left_channel_audio_in   (left_channel_audio_in),
    .right_channel_audio_in  (right_channel_audio_in),
    .filter_choice           (filter_choice),
    .filter_reset            (filter_reset),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .busy                    (busy)
  );

  always #5 AUD_BCLK = ~AUD_BCLK;

  int total = 0;
  int bad = 0;
  logic chk_tgl = 1'b0;

  string       q_name[$];
  logic [1:0]  q_ch[$];
  logic        q_rs[$];
  logic        q_bs[$];
  logic [31:0] q_l[$];
  logic [31:0] q_r[$];

  // Signed scaling reference: (in * g) >>> 6
  function automatic logic [31:0] scale(input logic [31:0] in, input int g);
    longint p;
    p = longint'($signed(in)) * longint'(g);
    p = p >>> 6;
    return p[31:0];
  endfunction

  // Spec timeline for a switch; t = 1 is the first sample carrying the new request
  task automatic sched(input int t, input logic [1:0] from, input logic [1:0] to,
                       output logic [1:0] ch, output logic rs, output logic bs, output int g);
    if (t <= 16)       g = 64;
    else if (t <= 80)  g = 64 - (t - 16);
    else if (t <= 84)  g = 0;
    else if (t <= 148) g = t - 84;
    else               g = 64;
    ch = (t >= 80) ? to : from;
    rs = (t >= 80) && (t < 84);
    bs = (t >= 16) && (t < 148);
  endtask

  task automatic push_exp(input string nm, input logic [1:0] ch, input logic rs,
                          input logic bs, input logic [31:0] l, input logic [31:0] r);
    q_name.push_back(nm);
    q_ch.push_back(ch);
    q_rs.push_back(rs);
    q_bs.push_back(bs);
    q_l.push_back(l);
    q_r.push_back(r);
  endtask

  // One sample period; the falling LRCK edge lands after outputs have settled
  task automatic do_tick();
    AUD_DACLRCK = 1'b1;
    repeat (4) @(negedge AUD_BCLK);
    AUD_DACLRCK = 1'b0;
    repeat (4) @(negedge AUD_BCLK);
  endtask

  task automatic step(input string nm, input int t, input logic [1:0] from, input logic [1:0] to);
    logic [1:0] ch;
    logic rs, bs;
    int g;
    sched(t, from, to, ch, rs, bs, g);
    push_exp($sformatf("%s_t%0d", nm, t), ch, rs, bs,
             scale(left_channel_audio_in, g), scale(right_channel_audio_in, g));
    do_tick();
  endtask

  // Monitor: compare on each sample boundary or on an explicit immediate check
  initial begin : monitor
    string nm;
    logic [1:0] ch;
    logic rs, bs;
    logic [31:0] l, r;
    forever begin
      @(negedge AUD_DACLRCK or chk_tgl);
      if (q_name.size() > 0) begin
        nm = q_name.pop_front();
        ch = q_ch.pop_front();
        rs = q_rs.pop_front();
        bs = q_bs.pop_front();
        l  = q_l.pop_front();
        r  = q_r.pop_front();
        total++;
        if (filter_choice !== ch || filter_reset !== rs || busy !== bs ||
            left_channel_audio_out !== l || right_channel_audio_out !== r) begin
          bad++;
          $display("FAIL %s: got sel=%0d rst=%0b busy=%0b l=%h r=%h, want sel=%0d rst=%0b busy=%0b l=%h r=%h",
                   nm, filter_choice, filter_reset, busy, left_channel_audio_out,
                   right_channel_audio_out, ch, rs, bs, l, r);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    @(negedge AUD_BCLK);
    // Reset held while LRCK keeps running
    do_tick();
    push_exp("reset_hold", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_tgl = ~chk_tgl;
    #1;
    @(negedge AUD_BCLK);
    reset_n = 1'b1;
    left_channel_audio_in = 32'h0000_1234;
    @(negedge AUD_BCLK);
    push_exp("post_reset_unity", 2'b00, 1'b0, 1'b0, 32'h0000_1234, 32'hFFFF_FFE0);
    chk_tgl = ~chk_tgl;
    #1;
    @(negedge AUD_BCLK);
    left_channel_audio_in = 32'h0000_1000;

    // Short glitch on the request never triggers a switch
    filter_choice_req = 2'b01;
    for (int t = 1; t <= 10; t++) step("glitch_hi", 1, 2'b00, 2'b00);
    filter_choice_req = 2'b00;
    for (int t = 1; t <= 20; t++) step("glitch_lo", 1, 2'b00, 2'b00);

    // Full 00 -> 01 switch; gain 32 reached at t = 48
    filter_choice_req = 2'b01;
    for (int t = 1; t <= 150; t++) begin
      if (t == 48) begin
        push_exp("gain32_hand", 2'b00, 1'b0, 1'b1, 32'h0000_0800, 32'hFFFF_FFF0);
        do_tick();
      end else begin
        step("sw_00_01", t, 2'b00, 2'b01);
      end
    end

    // Back to 00
    filter_choice_req = 2'b00;
    for (int t = 1; t <= 148; t++) step("sw_01_00", t, 2'b01, 2'b00);

    // 00 -> 01, with a request for 10 arriving during fade-in
    filter_choice_req = 2'b01;
    for (int t = 1; t <= 148; t++) begin
      if (t == 91) filter_choice_req = 2'b10;
      step("sw_late_req", t, 2'b00, 2'b01);
    end
    for (int t = 1; t <= 148; t++) step("sw_01_10", t, 2'b01, 2'b10);

    // Reset pulsed during the flush window
    filter_choice_req = 2'b11;
    for (int t = 1; t <= 82; t++) step("sw_10_11", t, 2'b10, 2'b11);
    reset_n = 1'b0;
    #1;
    push_exp("reset_in_flush", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_tgl = ~chk_tgl;
    #1;
    @(negedge AUD_BCLK);
    reset_n = 1'b1;
    @(negedge AUD_BCLK);
    push_exp("reset_full_gain", 2'b00, 1'b0, 1'b0, 32'h0000_1000, 32'hFFFF_FFE0);
    chk_tgl = ~chk_tgl;
    #1;
    @(negedge AUD_BCLK);

    // Request 11 restarts debounce from scratch against select 00
    for (int t = 1; t <= 17; t++) step("after_reset", t, 2'b00, 2'b11);

    repeat (4) @(negedge AUD_BCLK);
    total++;
    if (q_name.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q_name.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
